mx_alu_arb: RTL and testbench

MX_ALU_ARB -- requirements
Module: mx_alu_arb

---
 rtl/mx_alu_arb.sv | 159 +++++++++++++++
 tb/tb_mx_alu_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mx_alu_arb.sv
// Round-robin share of one mx_alu by NUM_REQ requesters, with an in-order response FIFO. Defining MX_ALU_ARB_PERF_EN adds grant and stall counters.
// Request-to-response latency is ALU_LATENCY+2. Grants stop while RESP_DEPTH commands are outstanding, and the FIFO pops on rsp_valid&rsp_ready.
module mx_alu_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int CMD_W       = 96,
  parameter int RES_W       = 48,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  output logic                       alu_cmd_valid,
  output logic [CMD_W-1:0]           alu_cmd,
  input  logic                       alu_res_valid,
  input  logic [RES_W-1:0]           alu_res,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [RES_W-1:0]           rsp_data,
  input  logic                       rsp_ready,
  output logic                       busy,
`ifdef MX_ALU_ARB_PERF_EN
  output logic                       err,
  output logic [31:0]                perf_grant_cnt,
  output logic [31:0]                perf_stall_cnt
`else
  output logic                       err
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OUT_W = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] data;
  } rsp_ent_t;

  logic [ID_W-1:0]  last_grant, win_id, cmd_id, idx;
  logic             win_vld, hs, credit_ok;
  logic [CMD_W-1:0] cmd_arr [NUM_REQ];
  logic [OUT_W-1:0] outstanding, cnt;
  logic [ALU_LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]  tag_id [ALU_LATENCY];
  logic             head_vld, push, pop, drop, stray;
  logic [ID_W-1:0]  head_id;
  rsp_ent_t         mem [RESP_DEPTH];
  rsp_ent_t         head_ent;
  logic [PTR_W-1:0] wptr, rptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cmd_arr[i] = req_cmd[i*CMD_W +: CMD_W];
  end

  // Walk backwards so the candidate nearest last_grant+1 is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign credit_ok = (outstanding < OUT_W'(RESP_DEPTH));

  always_comb begin
    req_ready = '0;
    if (win_vld && credit_ok && !rst) req_ready[win_id] = 1'b1;
  end

  assign hs       = |req_ready;
  assign head_vld = tag_vld[ALU_LATENCY-1];
  assign head_id  = tag_id[ALU_LATENCY-1];
  assign push     = alu_res_valid & head_vld;
  assign drop     = head_vld & ~alu_res_valid;
  assign stray    = alu_res_valid & ~head_vld;
  assign rsp_valid = (cnt != '0);
  assign pop      = rsp_valid & rsp_ready;
  assign head_ent = mem[rptr];
  assign rsp_id   = rsp_valid ? head_ent.id : '0;
  assign rsp_data = rsp_valid ? head_ent.data : '0;
  assign busy     = (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= ID_W'(NUM_REQ - 1);
      alu_cmd_valid <= 1'b0;
      alu_cmd       <= '0;
      cmd_id        <= '0;
      outstanding   <= '0;
      err           <= 1'b0;
    end else begin
      alu_cmd_valid <= hs;
      if (hs) begin
        alu_cmd    <= cmd_arr[win_id];
        cmd_id     <= win_id;
        last_grant <= win_id;
      end
      // A push only moves a command from in-flight to queued, so it leaves the count alone.
      outstanding <= outstanding + OUT_W'(hs) - OUT_W'(pop) - OUT_W'(drop);
      if (stray || drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= alu_cmd_valid;
      for (int i = 1; i < ALU_LATENCY; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= cmd_id;
    for (int i = 1; i < ALU_LATENCY; i++) tag_id[i] <= tag_id[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      cnt <= cnt + OUT_W'(push) - OUT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{id: head_id, data: alu_res};
  end

`ifdef MX_ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hs) perf_grant_cnt <= perf_grant_cnt + 32'd1;
      if ((|req_valid) && !(|req_ready)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mx_alu_arb.sv
// Directed bench for mx_alu_arb (NUM_REQ=4, ALU_LATENCY=1, RESP_DEPTH=4) with a one-cycle ALU stand-in.
module tb_mx_alu_arb;
  localparam logic [95:0] CMD0 = 96'hA0A0_0000_0000_0000_0000_0010;
  localparam logic [95:0] CMD1 = 96'hB1B1_0000_0000_0000_0000_0011;
  localparam logic [95:0] CMD2 = 96'hC2C2_0000_0000_0000_0000_0012;
  localparam logic [95:0] CMD3 = 96'hD3D3_0000_0000_0000_0000_0013;

  logic         clk, rst;
  logic [3:0]   req_valid, req_ready;
  logic [383:0] req_cmd;
  logic         alu_cmd_valid, alu_res_valid, rsp_valid, rsp_ready, busy, err;
  logic [95:0]  alu_cmd;
  logic [47:0]  alu_res, rsp_data;
  logic [1:0]   rsp_id;
`ifdef MX_ALU_ARB_PERF_EN
  logic [31:0]  perf_grant_cnt, perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mx_alu_arb #(.NUM_REQ(4), .ALU_LATENCY(1), .CMD_W(96), .RES_W(48), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .alu_cmd_valid(alu_cmd_valid), .alu_cmd(alu_cmd),
    .alu_res_valid(alu_res_valid), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy),
`ifdef MX_ALU_ARB_PERF_EN
    .err(err), .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`else
    .err(err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the ALU stand-in returns cmd[47:0]+1 one cycle after alu_cmd_valid and is flushed by rst.
  task automatic tick();
    logic        v;
    logic [95:0] c;
    v = alu_cmd_valid & ~rst;
    c = alu_cmd;
    @(posedge clk);
    #1;
    alu_res_valid = v;
    alu_res       = c[47:0] + 48'd1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] s2_rdy [8];
  logic [3:0] s3_rdy [12];

  initial begin
    s2_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    s3_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
               4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    rst = 1'b1;
    req_valid = 4'b0000;
    req_cmd = {CMD3, CMD2, CMD1, CMD0};
    alu_res_valid = 1'b0;
    alu_res = '0;
    rsp_ready = 1'b1;

    tick();
    tick();
    #1;
    check_eq("rst_req_ready", 128'(req_ready), 128'h0);
    check_eq("rst_alu_cmd_valid", 128'(alu_cmd_valid), 128'h0);
    check_eq("rst_alu_cmd", 128'(alu_cmd), 128'h0);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'h0);
    check_eq("rst_rsp_data", 128'(rsp_data), 128'h0);
    check_eq("rst_busy", 128'(busy), 128'h0);
    check_eq("rst_err", 128'(err), 128'h0);
    tick();
    rst = 1'b0;

    // Lone request from requester 2.
    tick(); req_valid = 4'b0100; #1;
    check_eq("s1_req_ready", 128'(req_ready), 128'h4);
    tick(); req_valid = 4'b0000; #1;
    check_eq("s1_alu_cmd_valid", 128'(alu_cmd_valid), 128'h1);
    check_eq("s1_alu_cmd", 128'(alu_cmd), 128'(CMD2));
    check_eq("s1_busy", 128'(busy), 128'h1);
    tick(); #1;
    check_eq("s1_rsp_early", 128'(rsp_valid), 128'h0);
    tick(); #1;
    check_eq("s1_rsp_valid", 128'(rsp_valid), 128'h1);
    check_eq("s1_rsp_id", 128'(rsp_id), 128'h2);
    check_eq("s1_rsp_data", 128'(rsp_data), 128'h13);
    tick(); #1;
    check_eq("s1_rsp_gone", 128'(rsp_valid), 128'h0);
    check_eq("s1_idle", 128'(busy), 128'h0);

    // All requesters valid for five cycles, consumer always ready.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 6) check_eq($sformatf("s2_rdy%0d", k), 128'(req_ready), 128'(s2_rdy[k]));
      if (k >= 3) begin
        check_eq($sformatf("s2_rsp_valid%0d", k), 128'(rsp_valid), 128'h1);
        check_eq($sformatf("s2_rsp_id%0d", k), 128'(rsp_id), 128'((k - 3) % 4));
        check_eq($sformatf("s2_rsp_data%0d", k), 128'(rsp_data), 128'(48'h11 + 48'((k - 3) % 4)));
      end
    end
`ifdef MX_ALU_ARB_PERF_EN
    check_eq("s2_perf_grant", 128'(perf_grant_cnt), 128'd5);
`endif
    tick(); #1;
    check_eq("s2_idle", 128'(busy), 128'h0);

    // Consumer stalled: four credits, then one pop frees exactly one grant.
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      req_valid = 4'b1111;
      rsp_ready = (k == 8);
      #1;
      check_eq($sformatf("s3_rdy%0d", k), 128'(req_ready), 128'(s3_rdy[k]));
`ifdef MX_ALU_ARB_PERF_EN
      if (k >= 4 && k <= 8) check_eq($sformatf("s3_stall%0d", k), 128'(perf_stall_cnt), 128'(k - 4));
      if (k == 10) check_eq("s3_stall10", 128'(perf_stall_cnt), 128'd5);
`endif
      if (k == 8) check_eq("s3_head_before", 128'(rsp_id), 128'h0);
      if (k == 9) check_eq("s3_head_after", 128'(rsp_id), 128'h1);
      if (k == 10) begin
        check_eq("s3_regrant_valid", 128'(alu_cmd_valid), 128'h1);
        check_eq("s3_regrant_cmd", 128'(alu_cmd), 128'(CMD0));
      end
      if (k == 11) check_eq("s3_no_more_issue", 128'(alu_cmd_valid), 128'h0);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    #1;
    check_eq("s3_drained_busy", 128'(busy), 128'h0);
    check_eq("s3_drained_rsp", 128'(rsp_valid), 128'h0);

    // Stray ALU result with nothing in flight.
    check_eq("s4_err_before", 128'(err), 128'h0);
    tick(); alu_res_valid = 1'b1; alu_res = 48'hDEAD; #1;
    tick(); #1;
    check_eq("s4_err_set", 128'(err), 128'h1);
    check_eq("s4_no_rsp", 128'(rsp_valid), 128'h0);
    tick(); tick(); tick(); #1;
    check_eq("s4_err_sticky", 128'(err), 128'h1);
    check_eq("s4_no_rsp_late", 128'(rsp_valid), 128'h0);

    // Reset lands one cycle after two grants.
    do_reset();
    #1;
    check_eq("s5_err_cleared", 128'(err), 128'h0);
    tick(); req_valid = 4'b0011; #1;
    check_eq("s5_grant0", 128'(req_ready), 128'h1);
    tick(); req_valid = 4'b0010; #1;
    check_eq("s5_grant1", 128'(req_ready), 128'h2);
    tick(); req_valid = 4'b0000; rst = 1'b1; #1;
    tick(); rst = 1'b0; #1;
    check_eq("s5_alu_cmd_valid", 128'(alu_cmd_valid), 128'h0);
    check_eq("s5_alu_cmd", 128'(alu_cmd), 128'h0);
    check_eq("s5_rsp_valid", 128'(rsp_valid), 128'h0);
    check_eq("s5_rsp_data", 128'(rsp_data), 128'h0);
    check_eq("s5_busy", 128'(busy), 128'h0);
    check_eq("s5_err", 128'(err), 128'h0);
    check_eq("s5_req_ready", 128'(req_ready), 128'h0);
    for (int k = 4; k < 8; k++) begin
      tick(); #1;
      check_eq($sformatf("s5_no_rsp%0d", k), 128'(rsp_valid), 128'h0);
      check_eq($sformatf("s5_no_err%0d", k), 128'(err), 128'h0);
    end
    tick(); req_valid = 4'b1111; #1;
    check_eq("s5_first_after_rst", 128'(req_ready), 128'h1);
    tick(); req_valid = 4'b0000;
    for (int k = 0; k < 6; k++) tick();
    #1;
    check_eq("s5_final_idle", 128'(busy), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
